// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA scan generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    function automatic int scan_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster timing bundle from the scan generator to the region testers
// and the VGA connector.
interface vga_scan_gen_if;
    import vga_timing_pkg::*;

    logic               pix_en;
    logic [COORD_W-1:0] visible_col;
    logic [COORD_W-1:0] visible_row;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               line_tick;
    logic               frame_tick;

    modport master (
        output pix_en, visible_col, visible_row, video_on,
               hsync, vsync, line_tick, frame_tick
    );

    modport slave (
        input pix_en, visible_col, visible_row, video_on,
              hsync, vsync, line_tick, frame_tick
    );

endinterface

// File: rtl/pix_en_div.sv
// Pixel-enable divider: pix_en is high for one clk in every CLK_DIV clks,
// decoded combinationally from the divider count.
module pix_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic BTN_S_n,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge BTN_S_n) begin
        if (!BTN_S_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_scan_gen.sv
// Raster-scan timing generator: h/v counters advanced on pix_en and a
// registered output stage holding coordinates, syncs and line/frame ticks.
module vga_scan_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int CLK_DIV   = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           BTN_S_n,
    vga_scan_gen_if.master scan
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL = scan_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = scan_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || CLK_DIV < 1) begin : g_bad_cfg
        $error("vga_scan_gen: totals must not exceed 2048 and CLK_DIV must be >= 1");
    end

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic   pix_en;
    coord_t h_cnt;
    coord_t v_cnt;
    logic   visible;
    logic   h_wrap;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_div (
        .clk     (clk),
        .BTN_S_n (BTN_S_n),
        .pix_en  (pix_en)
    );

    assign scan.pix_en = pix_en;
    assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign h_wrap      = pix_en && (h_cnt == H_LAST);

    always_ff @(posedge clk or negedge BTN_S_n) begin
        if (!BTN_S_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
            end else begin
                h_cnt <= h_cnt + coord_t'(1);
            end
        end
    end

    // Output stage samples the pre-edge counters, so every output lags the
    // counters by one clk and all of them stay mutually aligned.
    always_ff @(posedge clk or negedge BTN_S_n) begin
        if (!BTN_S_n) begin
            scan.video_on    <= 1'b0;
            scan.visible_col <= '0;
            scan.visible_row <= '0;
            scan.hsync       <= ~HS_POL;
            scan.vsync       <= ~VS_POL;
            scan.line_tick   <= 1'b0;
            scan.frame_tick  <= 1'b0;
        end else begin
            scan.video_on    <= visible;
            scan.visible_col <= visible ? h_cnt : '0;
            scan.visible_row <= visible ? v_cnt : '0;
            scan.hsync       <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? HS_POL : ~HS_POL;
            scan.vsync       <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? VS_POL : ~VS_POL;
            scan.line_tick   <= h_wrap;
            scan.frame_tick  <= h_wrap && (v_cnt == V_LAST);
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Runs three scan generators (default, tiny golden, odd-divider) from one reset
// against a closed-form model derived from the number of clks since release.
module tb_vga_scan_gen;

    typedef struct packed {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int cd;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        bit pix_en;
        int col, row;
        bit video_on, hsync, vsync, line_tick, frame_tick;
    } obs_t;

    localparam cfg_t CFG_A = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                               cd: 2, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CFG_B = '{hv: 4, hf: 1, hs: 2, hb: 1, vv: 3, vf: 1, vs: 1, vb: 1,
                               cd: 1, hp: 1'b1, vp: 1'b1};
    localparam cfg_t CFG_C = '{hv: 20, hf: 3, hs: 5, hb: 4, vv: 12, vf: 2, vs: 3, vb: 2,
                               cd: 3, hp: 1'b0, vp: 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_scan_gen_if if_a ();
    vga_scan_gen_if if_b ();
    vga_scan_gen_if if_c ();

    vga_scan_gen #(
        .H_VISIBLE(CFG_A.hv), .H_FRONT(CFG_A.hf), .H_SYNC(CFG_A.hs), .H_BACK(CFG_A.hb),
        .V_VISIBLE(CFG_A.vv), .V_FRONT(CFG_A.vf), .V_SYNC(CFG_A.vs), .V_BACK(CFG_A.vb),
        .CLK_DIV(CFG_A.cd), .HS_POL(CFG_A.hp), .VS_POL(CFG_A.vp)
    ) dut_a (.clk(clk), .BTN_S_n(rst_n), .scan(if_a.master));

    vga_scan_gen #(
        .H_VISIBLE(CFG_B.hv), .H_FRONT(CFG_B.hf), .H_SYNC(CFG_B.hs), .H_BACK(CFG_B.hb),
        .V_VISIBLE(CFG_B.vv), .V_FRONT(CFG_B.vf), .V_SYNC(CFG_B.vs), .V_BACK(CFG_B.vb),
        .CLK_DIV(CFG_B.cd), .HS_POL(CFG_B.hp), .VS_POL(CFG_B.vp)
    ) dut_b (.clk(clk), .BTN_S_n(rst_n), .scan(if_b.master));

    vga_scan_gen #(
        .H_VISIBLE(CFG_C.hv), .H_FRONT(CFG_C.hf), .H_SYNC(CFG_C.hs), .H_BACK(CFG_C.hb),
        .V_VISIBLE(CFG_C.vv), .V_FRONT(CFG_C.vf), .V_SYNC(CFG_C.vs), .V_BACK(CFG_C.vb),
        .CLK_DIV(CFG_C.cd), .HS_POL(CFG_C.hp), .VS_POL(CFG_C.vp)
    ) dut_c (.clk(clk), .BTN_S_n(rst_n), .scan(if_c.master));

    obs_t act_a, act_b, act_c;
    always_comb act_a = '{pix_en: if_a.pix_en, col: int'(if_a.visible_col), row: int'(if_a.visible_row),
                          video_on: if_a.video_on, hsync: if_a.hsync, vsync: if_a.vsync,
                          line_tick: if_a.line_tick, frame_tick: if_a.frame_tick};
    always_comb act_b = '{pix_en: if_b.pix_en, col: int'(if_b.visible_col), row: int'(if_b.visible_row),
                          video_on: if_b.video_on, hsync: if_b.hsync, vsync: if_b.vsync,
                          line_tick: if_b.line_tick, frame_tick: if_b.frame_tick};
    always_comb act_c = '{pix_en: if_c.pix_en, col: int'(if_c.visible_col), row: int'(if_c.visible_row),
                          video_on: if_c.video_on, hsync: if_c.hsync, vsync: if_c.vsync,
                          line_tick: if_c.line_tick, frame_tick: if_c.frame_tick};

    int n_cmp = 0;
    int n_bad = 0;
    int m     = 0;   // clk edges seen since reset release
    int cyc   = 0;

    bit [1:0] prev_a, prev_b, prev_c;
    int hs_run, hs_pulses, n_line_a, last_line_a, last_frame_b, n_frame_b, n_frame_c;

    // Expected outputs after m edges: edge k shows the raster position reached
    // after k-1 edges, i.e. pixel floor((k-1)/cd) of the frame.
    function automatic obs_t model(input cfg_t c, input int edges);
        obs_t e;
        int ht, vt, s, p, h, v;
        bit pe_pre, vis;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        e = '0;
        e.pix_en = ((edges % c.cd) == c.cd - 1);
        if (edges == 0) begin
            e.hsync = ~c.hp;
            e.vsync = ~c.vp;
            return e;
        end
        s      = edges - 1;
        p      = s / c.cd;
        h      = p % ht;
        v      = (p / ht) % vt;
        pe_pre = ((s % c.cd) == c.cd - 1);
        vis    = (h < c.hv) && (v < c.vv);
        e.video_on   = vis;
        e.col        = vis ? h : 0;
        e.row        = vis ? v : 0;
        e.hsync      = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.hp : ~c.hp;
        e.vsync      = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.vp : ~c.vp;
        e.line_tick  = pe_pre && (h == ht - 1);
        e.frame_tick = pe_pre && (h == ht - 1) && (v == vt - 1);
        return e;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic check_dut(input string n, input cfg_t c, input obs_t a, input bit [1:0] prev);
        obs_t e;
        e = model(c, m);
        if (rst_n || c.cd > 1) check({n, " pix_en"}, int'(a.pix_en), int'(e.pix_en));
        check({n, " video_on"},   int'(a.video_on),   int'(e.video_on));
        check({n, " col"},        a.col,              e.col);
        check({n, " row"},        a.row,              e.row);
        check({n, " hsync"},      int'(a.hsync),      int'(e.hsync));
        check({n, " vsync"},      int'(a.vsync),      int'(e.vsync));
        check({n, " line_tick"},  int'(a.line_tick),  int'(e.line_tick));
        check({n, " frame_tick"}, int'(a.frame_tick), int'(e.frame_tick));
        if (!a.video_on) check({n, " blank coords zero"}, a.col | a.row, 0);
        check({n, " tick twice"}, int'(prev & {a.line_tick, a.frame_tick}), 0);
    endtask

    task automatic check_all();
        check_dut("a", CFG_A, act_a, prev_a);
        check_dut("b", CFG_B, act_b, prev_b);
        check_dut("c", CFG_C, act_c, prev_c);
        prev_a = {act_a.line_tick, act_a.frame_tick};
        prev_b = {act_b.line_tick, act_b.frame_tick};
        prev_c = {act_c.line_tick, act_c.frame_tick};
    endtask

    task automatic clear_trackers();
        hs_run = 0; hs_pulses = 0; n_line_a = 0; last_line_a = -1;
        last_frame_b = -1; n_frame_b = 0; n_frame_c = 0;
        prev_a = '0; prev_b = '0; prev_c = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) m++;
        @(negedge clk);
        cyc++;
        check_all();
        if (act_a.line_tick) begin
            if (last_line_a >= 0) check("a line period", cyc - last_line_a, 1600);
            last_line_a = cyc;
            n_line_a++;
        end
        if (!act_a.hsync) begin
            hs_run++;
        end else if (hs_run > 0) begin
            check("a hsync width", hs_run, 192);
            hs_pulses++;
            hs_run = 0;
        end
        if (act_b.frame_tick) begin
            if (last_frame_b >= 0) check("b frame period", cyc - last_frame_b, 48);
            last_frame_b = cyc;
            n_frame_b++;
        end
        if (act_c.frame_tick) n_frame_c++;
    endtask

    // Assert reset between clock edges, check the asynchronous drop, hold, release.
    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        m = 0;
        #1 check_all();
        clear_trackers();
        repeat (hold) step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_trackers();
        repeat (3) step();
        rst_n = 1'b1;

        // Default geometry: three lines plus a little, from release.
        repeat (3 * 1600 + 21) step();
        check("a line ticks", n_line_a, 3);
        check("a hsync pulses", hs_pulses, 3);

        // Resets at random raster positions.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(100, 2500)) step();
            do_reset(3);
        end

        // Ten frames of the odd-divider config and 380 of the tiny config.
        repeat (10 * 1824) step();
        check("c frame ticks", n_frame_c, 10);
        check("b frame ticks", n_frame_b, 10 * 1824 / 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
